// File: rtl/id_pipeline.sv
// RV32I decode stage: instruction decode, register file with write-back bypass,
// immediate generation, load-use stall detection and the ID/EX pipeline register.
module id_pipeline #(
  parameter int PC_WIDTH = 16,
  parameter int XLEN     = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr_D,
  input  logic [PC_WIDTH-1:0] pc_D,
  input  logic                flush_E,
  input  logic                wb_en_W,
  input  logic [4:0]          wb_rd_W,
  input  logic [XLEN-1:0]     wb_data_W,
  output logic                IF_pipeline_write_zero,
  output logic                pc_write_zero,
  output logic [XLEN-1:0]     rs1_data_E,
  output logic [XLEN-1:0]     rs2_data_E,
  output logic [XLEN-1:0]     imm_E,
  output logic [4:0]          rs1_E,
  output logic [4:0]          rs2_E,
  output logic [4:0]          rd_E,
  output logic [PC_WIDTH-1:0] pc_E,
  output logic [3:0]          alu_op_E,
  output logic [2:0]          funct3_E,
  output logic                reg_write_E,
  output logic                mem_read_E,
  output logic                mem_write_E,
  output logic                branch_E,
  output logic                jump_E,
  output logic                jalr_E,
  output logic                alu_src_E,
  output logic                alu_a_pc_E,
  output logic                mem_to_reg_E
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic [4:0] rs1_D, rs2_D, rd_D;

  assign opcode    = instr_D[6:0];
  assign funct3    = instr_D[14:12];
  assign funct7_b5 = instr_D[30];
  assign rs1_D     = instr_D[19:15];
  assign rs2_D     = instr_D[24:20];
  assign rd_D      = instr_D[11:7];

  logic [3:0]      alu_op;
  logic [XLEN-1:0] imm;
  logic            reg_write, mem_read, mem_write, branch, jump, jalr;
  logic            alu_src, alu_a_pc, mem_to_reg, uses_rs2;

  // funct3 -> ALU op; SUB only exists for R-type, SRA/SRAI both via funct7[5].
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic b5,
                                                input logic is_r);
    case (f3)
      3'b000:  return (is_r && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    alu_op     = ALU_ADD;
    imm        = '0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
    alu_src    = 1'b0;
    alu_a_pc   = 1'b0;
    mem_to_reg = 1'b0;
    uses_rs2   = 1'b0;
    case (opcode)
      OP_R: begin
        alu_op    = alu_from_funct(funct3, funct7_b5, 1'b1);
        reg_write = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_I_ALU: begin
        alu_op    = alu_from_funct(funct3, funct7_b5, 1'b0);
        imm       = {{(XLEN-12){instr_D[31]}}, instr_D[31:20]};
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LOAD: begin
        imm        = {{(XLEN-12){instr_D[31]}}, instr_D[31:20]};
        alu_src    = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      OP_STORE: begin
        imm       = {{(XLEN-12){instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
        alu_src   = 1'b1;
        mem_write = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_BRANCH: begin
        alu_op   = ALU_SUB;
        imm      = {{(XLEN-12){instr_D[31]}}, instr_D[7], instr_D[30:25],
                    instr_D[11:8], 1'b0};
        branch   = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        imm       = {{(XLEN-20){instr_D[31]}}, instr_D[19:12], instr_D[20],
                     instr_D[30:21], 1'b0};
        jump      = 1'b1;
        reg_write = 1'b1;
      end
      OP_JALR: begin
        imm       = {{(XLEN-12){instr_D[31]}}, instr_D[31:20]};
        jump      = 1'b1;
        jalr      = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_LUI: begin
        alu_op    = ALU_PASSB;
        imm       = {{(XLEN-31){instr_D[31]}}, instr_D[30:12], 12'b0};
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm       = {{(XLEN-31){instr_D[31]}}, instr_D[30:12], 12'b0};
        alu_a_pc  = 1'b1;
        alu_src   = 1'b1;
        reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Register file; x0 is never written so entry 0 stays at its reset value of 0.
  logic [XLEN-1:0] regs [0:31];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is small and must read as zero after reset, so it is
      // cleared with the rest of the state rather than left to a RAM macro.
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wb_en_W && wb_rd_W != 5'd0) begin
      regs[wb_rd_W] <= wb_data_W;
    end
  end

  logic [XLEN-1:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = regs[rs1_D];
    rs2_val = regs[rs2_D];
    if (wb_en_W && wb_rd_W == rs1_D && rs1_D != 5'd0) rs1_val = wb_data_W;
    if (wb_en_W && wb_rd_W == rs2_D && rs2_D != 5'd0) rs2_val = wb_data_W;
  end

  logic hazard, bubble;

  assign hazard = mem_read_E && rd_E != 5'd0 &&
                  (rd_E == rs1_D || (uses_rs2 && rd_E == rs2_D));
  assign bubble = hazard || flush_E;

  // A taken branch/jump kills the stalled instruction anyway, so flush overrides stall.
  assign IF_pipeline_write_zero = hazard && !flush_E;
  assign pc_write_zero          = hazard && !flush_E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || bubble) begin
      // NOTE: state is updated only with non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      rs1_data_E   <= '0;
      rs2_data_E   <= '0;
      imm_E        <= '0;
      rs1_E        <= '0;
      rs2_E        <= '0;
      rd_E         <= '0;
      pc_E         <= '0;
      alu_op_E     <= '0;
      funct3_E     <= '0;
      reg_write_E  <= 1'b0;
      mem_read_E   <= 1'b0;
      mem_write_E  <= 1'b0;
      branch_E     <= 1'b0;
      jump_E       <= 1'b0;
      jalr_E       <= 1'b0;
      alu_src_E    <= 1'b0;
      alu_a_pc_E   <= 1'b0;
      mem_to_reg_E <= 1'b0;
    end else begin
      rs1_data_E   <= rs1_val;
      rs2_data_E   <= rs2_val;
      imm_E        <= imm;
      rs1_E        <= rs1_D;
      rs2_E        <= rs2_D;
      rd_E         <= reg_write ? rd_D : 5'd0;
      pc_E         <= pc_D;
      alu_op_E     <= alu_op;
      funct3_E     <= funct3;
      reg_write_E  <= reg_write;
      mem_read_E   <= mem_read;
      mem_write_E  <= mem_write;
      branch_E     <= branch;
      jump_E       <= jump;
      jalr_E       <= jalr;
      alu_src_E    <= alu_src;
      alu_a_pc_E   <= alu_a_pc;
      mem_to_reg_E <= mem_to_reg;
    end
  end

endmodule

// File: tb/tb_id_pipeline.sv
// Directed bench for id_pipeline: table-driven decode vectors plus hand-written
// sequences for load-use stall, flush priority and asynchronous reset.
module tb_id_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_D;
  logic [15:0] pc_D;
  logic        flush_E;
  logic        wb_en_W;
  logic [4:0]  wb_rd_W;
  logic [31:0] wb_data_W;
  logic        IF_pipeline_write_zero, pc_write_zero;
  logic [31:0] rs1_data_E, rs2_data_E, imm_E;
  logic [4:0]  rs1_E, rs2_E, rd_E;
  logic [15:0] pc_E;
  logic [3:0]  alu_op_E;
  logic [2:0]  funct3_E;
  logic        reg_write_E, mem_read_E, mem_write_E, branch_E, jump_E, jalr_E;
  logic        alu_src_E, alu_a_pc_E, mem_to_reg_E;

  always #5 clk = ~clk;

  id_pipeline #(.PC_WIDTH(16), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .instr_D(instr_D), .pc_D(pc_D), .flush_E(flush_E),
    .wb_en_W(wb_en_W), .wb_rd_W(wb_rd_W), .wb_data_W(wb_data_W),
    .IF_pipeline_write_zero(IF_pipeline_write_zero), .pc_write_zero(pc_write_zero),
    .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E), .imm_E(imm_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .pc_E(pc_E),
    .alu_op_E(alu_op_E), .funct3_E(funct3_E),
    .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
    .branch_E(branch_E), .jump_E(jump_E), .jalr_E(jalr_E), .alu_src_E(alu_src_E),
    .alu_a_pc_E(alu_a_pc_E), .mem_to_reg_E(mem_to_reg_E)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Control bundle order: reg_write mem_read mem_write branch jump jalr alu_src alu_a_pc mem_to_reg
  localparam logic [8:0] RW = 9'b100000000, MR = 9'b010000000, MW = 9'b001000000,
                         BR = 9'b000100000, JP = 9'b000010000, JR = 9'b000001000,
                         AS = 9'b000000100, AP = 9'b000000010, MT = 9'b000000001;

  function automatic logic [8:0] ctrl_now();
    return {reg_write_E, mem_read_E, mem_write_E, branch_E, jump_E, jalr_E,
            alu_src_E, alu_a_pc_E, mem_to_reg_E};
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] e_imm;
    logic [3:0]  e_alu;
    logic [2:0]  e_f3;
    logic [8:0]  e_ctrl;
    logic [31:0] e_d1, e_d2;
  } vec_t;

  vec_t vecs [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          instr         wbe  wbrd  wbdata        rd  rs1 rs2 imm           alu f3 ctrl           d1            d2
    vecs[0]  = '{32'h00500093, 1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 5'd5,  32'h5,        4'd0,  3'd0, RW|AS,       32'h0,        32'h0};
    vecs[1]  = '{32'h00010133, 1'b1, 5'd2, 32'hDEADBEEF, 5'd2, 5'd2, 5'd0,  32'h0,        4'd0,  3'd0, RW,          32'hDEADBEEF, 32'h0};
    vecs[2]  = '{32'h00000133, 1'b1, 5'd0, 32'h12345678, 5'd2, 5'd0, 5'd0,  32'h0,        4'd0,  3'd0, RW,          32'h0,        32'h0};
    vecs[3]  = '{32'hFE20AE23, 1'b1, 5'd1, 32'h00000100, 5'd0, 5'd1, 5'd2,  32'hFFFFFFFC, 4'd0,  3'd2, MW|AS,       32'h100,      32'hDEADBEEF};
    vecs[4]  = '{32'h008000EF, 1'b0, 5'd0, 32'h0,        5'd1, 5'd0, 5'd8,  32'h8,        4'd0,  3'd0, RW|JP,       32'h0,        32'h0};
    vecs[5]  = '{32'h12345237, 1'b0, 5'd0, 32'h0,        5'd4, 5'd8, 5'd3,  32'h12345000, 4'd10, 3'd5, RW|AS,       32'h0,        32'h0};
    vecs[6]  = '{32'h402083B3, 1'b0, 5'd0, 32'h0,        5'd7, 5'd1, 5'd2,  32'h0,        4'd1,  3'd0, RW,          32'h100,      32'hDEADBEEF};
    vecs[7]  = '{32'h4030D413, 1'b0, 5'd0, 32'h0,        5'd8, 5'd1, 5'd3,  32'h403,      4'd7,  3'd5, RW|AS,       32'h100,      32'h0};
    vecs[8]  = '{32'h00208863, 1'b0, 5'd0, 32'h0,        5'd0, 5'd1, 5'd2,  32'h10,       4'd1,  3'd0, BR,          32'h100,      32'hDEADBEEF};
    vecs[9]  = '{32'hFE000EE3, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  32'hFFFFFFFC, 4'd1,  3'd0, BR,          32'h0,        32'h0};
    vecs[10] = '{32'h00001497, 1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 5'd0,  32'h1000,     4'd0,  3'd1, RW|AS|AP,    32'h0,        32'h0};
    vecs[11] = '{32'h00C100E7, 1'b0, 5'd0, 32'h0,        5'd1, 5'd2, 5'd12, 32'hC,        4'd0,  3'd0, RW|JP|JR|AS, 32'hDEADBEEF, 32'h0};
    vecs[12] = '{32'h0000007F, 1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        4'd0,  3'd0, 9'd0,        32'h0,        32'h0};
    vecs[13] = '{32'h0000A283, 1'b0, 5'd0, 32'h0,        5'd5, 5'd1, 5'd0,  32'h0,        4'd0,  3'd2, RW|MR|AS|MT, 32'h100,      32'h0};

    reset = 1'b1; instr_D = '0; pc_D = '0; flush_E = 1'b0;
    wb_en_W = 1'b0; wb_rd_W = '0; wb_data_W = '0;
    #12;
    check("reset_ctrl", 32'(ctrl_now()), 32'h0);
    check("reset_rd", 32'(rd_E), 32'h0);
    check("reset_imm", imm_E, 32'h0);
    check("reset_stall", 32'(IF_pipeline_write_zero), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      instr_D = vecs[i].instr; pc_D = 16'(4 * (i + 1));
      wb_en_W = vecs[i].wb_en; wb_rd_W = vecs[i].wb_rd; wb_data_W = vecs[i].wb_data;
      #1;
      check($sformatf("v%0d_no_stall", i), 32'(pc_write_zero), 32'h0);
      tick();
      check($sformatf("v%0d_rd", i), 32'(rd_E), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_rs1", i), 32'(rs1_E), 32'(vecs[i].e_rs1));
      check($sformatf("v%0d_rs2", i), 32'(rs2_E), 32'(vecs[i].e_rs2));
      check($sformatf("v%0d_imm", i), imm_E, vecs[i].e_imm);
      check($sformatf("v%0d_alu", i), 32'(alu_op_E), 32'(vecs[i].e_alu));
      check($sformatf("v%0d_f3", i), 32'(funct3_E), 32'(vecs[i].e_f3));
      check($sformatf("v%0d_ctrl", i), 32'(ctrl_now()), 32'(vecs[i].e_ctrl));
      check($sformatf("v%0d_d1", i), rs1_data_E, vecs[i].e_d1);
      check($sformatf("v%0d_d2", i), rs2_data_E, vecs[i].e_d2);
      check($sformatf("v%0d_pc", i), 32'(pc_E), 4 * (i + 1));
    end
    wb_en_W = 1'b0;

    // lw x5 now in E; an I-type whose rs2 field happens to be 5 must not stall
    instr_D = 32'h00500313;
    #1;
    check("itype_rs2_no_stall", 32'(IF_pipeline_write_zero), 32'h0);
    instr_D = 32'h00528333;
    #1;
    check("lu_if_stall", 32'(IF_pipeline_write_zero), 32'h1);
    check("lu_pc_stall", 32'(pc_write_zero), 32'h1);
    tick();
    check("lu_bubble_rw", 32'(reg_write_E), 32'h0);
    check("lu_bubble_mr", 32'(mem_read_E), 32'h0);
    check("lu_stall_released", 32'(IF_pipeline_write_zero), 32'h0);
    tick();
    check("lu_redecode_rd", 32'(rd_E), 32'd6);
    check("lu_redecode_rs1", 32'(rs1_E), 32'd5);
    check("lu_redecode_rs2", 32'(rs2_E), 32'd5);
    check("lu_redecode_rw", 32'(reg_write_E), 32'h1);

    // Flush beats stall
    instr_D = 32'h0000A283;
    tick();
    instr_D = 32'h00528333; flush_E = 1'b1;
    #1;
    check("flush_if_stall", 32'(IF_pipeline_write_zero), 32'h0);
    check("flush_pc_stall", 32'(pc_write_zero), 32'h0);
    tick();
    flush_E = 1'b0;
    check("flush_bubble_ctrl", 32'(ctrl_now()), 32'h0);
    check("flush_bubble_rd", 32'(rd_E), 32'h0);

    // Asynchronous reset between edges with a valid instruction in E
    instr_D = 32'h12345237;
    tick();
    check("pre_reset_imm", imm_E, 32'h12345000);
    #2 reset = 1'b1;
    #1;
    check("async_rst_imm", imm_E, 32'h0);
    check("async_rst_rd", 32'(rd_E), 32'h0);
    check("async_rst_ctrl", 32'(ctrl_now()), 32'h0);
    check("async_rst_alu", 32'(alu_op_E), 32'h0);
    check("async_rst_pc", 32'(pc_E), 32'h0);
    reset = 1'b0;
    instr_D = 32'h000081B3;
    tick();
    check("post_rst_x1", rs1_data_E, 32'h0);
    check("post_rst_rd", 32'(rd_E), 32'd3);
    check("post_rst_rw", 32'(reg_write_E), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_pipeline.md
Name: id_pipeline

Overview:
Decode stage sitting directly downstream of the fetch stage (IF_pipeline). It consumes instr_D/pc_D, decodes RV32I, reads a 32x32 register file with write-back bypass, and generates immediates and control signals. It registers all results into the ID/EX pipeline register. It also detects load-use hazards and drives the fetch stage's IF_pipeline_write_zero/pc_write_zero stall inputs.

Parameters:
PC_WIDTH, 16, width of pc_D/pc_E
XLEN, 32, datapath/register width

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high; clears all state
instr_D  in  32  instruction from fetch stage
pc_D  in  PC_WIDTH  PC of instr_D
flush_E  in  1  branch/jump taken in EX (same event as fetch's pc_src); kill instruction in D
wb_en_W  in  1  write-back enable
wb_rd_W  in  5  write-back destination register
wb_data_W  in  XLEN  write-back data
IF_pipeline_write_zero  out  1  1 = hold IF/ID register (stall)
pc_write_zero  out  1  1 = hold PC (stall)
rs1_data_E, rs2_data_E  out  XLEN  registered operands
imm_E  out  XLEN  registered sign-extended immediate
rs1_E, rs2_E, rd_E  out  5  registered register indices (for forwarding)
pc_E  out  PC_WIDTH  registered PC
alu_op_E  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASSB
funct3_E  out  3  registered funct3 (branch/load/store width)
reg_write_E, mem_read_E, mem_write_E, branch_E, jump_E, jalr_E, alu_src_E, alu_a_pc_E, mem_to_reg_E  out  1 each  registered controls

Behaviour:
- Reset (async): every *_E output = 0 (bubble), all 32 registers = 0. Stall outputs are combinational and read 0 while the E register holds a bubble.
- Latency: instr_D present before posedge N appears decoded on *_E after posedge N (1 cycle).
- Decode by opcode:
  - R 0110011: alu_op from funct3/funct7[5]; reg_write.
  - I-ALU 0010011: alu_src; SRAI via funct7[5].
  - LOAD 0000011: ADD, alu_src, mem_read, mem_to_reg, reg_write.
  - STORE 0100011: ADD, alu_src, mem_write.
  - BRANCH 1100011: SUB, branch.
  - JAL 1101111: jump, reg_write.
  - JALR 1100111: jump, jalr, alu_src, reg_write.
  - LUI 0110111: PASSB, alu_src, reg_write.
  - AUIPC 0010111: ADD, alu_a_pc, alu_src, reg_write.
  - Any other opcode: all controls 0.
- Immediates: I/S/B/U/J formats, sign-extended from bit 31. U = instr[31:12]<<12. B and J have bit 0 = 0.
- rd_E = 0 when reg_write is 0 (stores/branches).
- Register file:
  - x0 always reads 0 and writes to it are ignored.
  - Write on posedge when wb_en_W.
  - Same-cycle bypass: if wb_en_W && wb_rd_W==rsX && rsX!=0, the operand read is wb_data_W.
- Load-use hazard: mem_read_E && rd_E!=0 && (rd_E==rs1_D, or rd_E==rs2_D where the D opcode uses rs2: R/STORE/BRANCH).
  - Hazard => IF_pipeline_write_zero=pc_write_zero=1 (combinational, same cycle).
  - Next posedge loads a bubble (all controls 0, other E fields don't-care but zero).
  - Fetch holds instr_D, so it is re-decoded next cycle. Stall lasts exactly 1 cycle.
- flush_E=1: next posedge loads a bubble; both stall outputs forced 0 that cycle (flush wins over stall).
- Reset asserted mid-operation: E outputs clear immediately without waiting for a clock; register contents are lost.

Test Plan:
- Reset, then instr_D=0x00500093 (addi x1,x0,5), pc_D=4 -> after 1 posedge: rd_E=1, imm_E=5, alu_src_E=1, reg_write_E=1, alu_op_E=0, pc_E=4, rs1_data_E=0.
- wb_en_W=1, wb_rd_W=2, wb_data_W=0xDEADBEEF with instr_D=0x00010133 (add x2,x2,x0) in the same cycle -> rs1_data_E=0xDEADBEEF. Repeat with wb_rd_W=0 -> x0 still reads 0.
- lw x5,0(x1) (0x0000A283), then add x6,x5,x5 (0x00528333):
  - Cycle with add in D: IF_pipeline_write_zero=pc_write_zero=1.
  - Next E: bubble (reg_write_E=0, mem_read_E=0).
  - Following E: rd_E=6, rs1_E=rs2_E=5.
- sw x2,-4(x1) (0xFE20AE23) -> imm_E=0xFFFFFFFC, mem_write_E=1, reg_write_E=0, rd_E=0. jal x1,8 (0x008000EF) -> imm_E=8, jump_E=1, reg_write_E=1.
- Load-use condition plus flush_E=1 in the same cycle -> stall outputs 0; next E is a bubble. Unknown opcode 0x0000007F -> all controls 0.
- Assert reset between clock edges while E holds a valid instruction -> all *_E outputs 0 immediately. After release, add x3,x1,x0 reads rs1_data_E=0.
